// File: rtl/reg_writeback_ctrl.sv
// Write-side controller for the 32x32 register file: merges ALU results and in-order
// load responses into one registered write port and reports RAW/WAW hazards to decode.
module reg_writeback_ctrl #(
  parameter int LQ_DEPTH = 4,
  parameter int LQ_AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        ld_issue_valid,
  output logic        ld_issue_ready,
  input  logic [4:0]  ld_issue_addr,
  input  logic        ld_resp_valid,
  input  logic [31:0] ld_resp_data,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  input  logic [4:0]  chk_addr3,
  output logic        hazard1,
  output logic        hazard2,
  output logic        hazard3,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  output logic        err_resp
);

  localparam logic [LQ_AW:0] PTR_ONE = (LQ_AW + 1)'(1);

  logic [4:0]       r_lq_addr [LQ_DEPTH];
  logic [LQ_AW:0]   r_wr_ptr;
  logic [LQ_AW:0]   r_rd_ptr;
  logic             r_skid_full;
  logic [4:0]       r_skid_addr;
  logic [31:0]      r_skid_data;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_alu_fire;
  logic [LQ_AW:0]   w_count;
  logic [4:0]       w_head_addr;
  logic [LQ_DEPTH-1:0] w_ent_valid;
  logic [4:0]       w_sel_addr;
  logic [31:0]      w_sel_data;
  logic             w_skid_load;
  logic             w_skid_drain;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[LQ_AW] != r_rd_ptr[LQ_AW]) &&
                       (r_wr_ptr[LQ_AW-1:0] == r_rd_ptr[LQ_AW-1:0]);
  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_head_addr = r_lq_addr[r_rd_ptr[LQ_AW-1:0]];

  assign ld_issue_ready = !w_full;
  assign alu_ready      = !r_skid_full;

  assign w_push     = ld_issue_valid && !w_full;
  assign w_pop      = ld_resp_valid && !w_empty;
  assign w_alu_fire = alu_valid && alu_ready;

  // Write-port arbitration: load response, then skid, then the live ALU beat.
  always_comb begin
    w_sel_addr   = 5'd0;
    w_sel_data   = 32'd0;
    w_skid_load  = 1'b0;
    w_skid_drain = 1'b0;
    if (w_pop) begin
      w_sel_addr  = w_head_addr;
      w_sel_data  = ld_resp_data;
      w_skid_load = w_alu_fire;
    end else if (r_skid_full) begin
      w_sel_addr   = r_skid_addr;
      w_sel_data   = r_skid_data;
      w_skid_drain = 1'b1;
    end else if (w_alu_fire) begin
      w_sel_addr = alu_addr;
      w_sel_data = alu_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_skid_full <= 1'b0;
      r_skid_addr <= 5'd0;
      r_skid_data <= 32'd0;
      write_addr  <= 5'd0;
      write_data  <= 32'd0;
      err_resp    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_skid_load) begin
        r_skid_full <= 1'b1;
        r_skid_addr <= alu_addr;
        r_skid_data <= alu_data;
      end else if (w_skid_drain) begin
        r_skid_full <= 1'b0;
      end
      write_addr <= w_sel_addr;
      write_data <= w_sel_data;
      if (ld_resp_valid && w_empty) err_resp <= 1'b1;
    end
  end

  // NOTE: queue storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_lq_addr[r_wr_ptr[LQ_AW-1:0]] <= ld_issue_addr;
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    w_ent_valid = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      w_ent_valid[i] = ({1'b0, LQ_AW'(i) - r_rd_ptr[LQ_AW-1:0]} < w_count);
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    hazard3 = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (w_ent_valid[i]) begin
        if (r_lq_addr[i] == chk_addr1) hazard1 = 1'b1;
        if (r_lq_addr[i] == chk_addr2) hazard2 = 1'b1;
        if (r_lq_addr[i] == chk_addr3) hazard3 = 1'b1;
      end
    end
    if (r_skid_full) begin
      if (r_skid_addr == chk_addr1) hazard1 = 1'b1;
      if (r_skid_addr == chk_addr2) hazard2 = 1'b1;
      if (r_skid_addr == chk_addr3) hazard3 = 1'b1;
    end
    // r0 is hardwired, so it never carries a pending value.
    if (chk_addr1 == 5'd0) hazard1 = 1'b0;
    if (chk_addr2 == 5'd0) hazard2 = 1'b0;
    if (chk_addr3 == 5'd0) hazard3 = 1'b0;
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Scoreboard bench for reg_writeback_ctrl: stimulus queues expected writes, a negedge
// monitor pops and compares every non-zero write; directed checks cover flags and timing.
module tb_reg_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ld_issue_valid;
  logic        ld_issue_ready;
  logic [4:0]  ld_issue_addr;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic [4:0]  chk_addr3;
  logic        hazard1;
  logic        hazard2;
  logic        hazard3;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        err_resp;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_vec = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;

  reg_writeback_ctrl #(.LQ_DEPTH(4), .LQ_AW(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready), .ld_issue_addr(ld_issue_addr),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_addr3(chk_addr3),
    .hazard1(hazard1), .hazard2(hazard2), .hazard3(hazard3),
    .write_addr(write_addr), .write_data(write_data), .err_resp(err_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid      = 1'b0;
    alu_addr       = 5'd0;
    alu_data       = 32'd0;
    ld_issue_valid = 1'b0;
    ld_issue_addr  = 5'd0;
    ld_resp_valid  = 1'b0;
    ld_resp_data   = 32'd0;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every non-zero write must match the oldest expected write.
  always @(negedge clk) begin
    if (mon_en && write_addr !== 5'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(write_addr), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(write_addr), 32'(mon_e.addr));
        check("wr_data", write_data, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    chk_addr1 = 5'd0;
    chk_addr2 = 5'd0;
    chk_addr3 = 5'd0;
    repeat (3) cyc();
    rst = 1'b0;
    mon_en = 1'b1;
    #1;
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    check("rst_ld_ready", 32'(ld_issue_ready), 32'd1);
    check("rst_write_addr", 32'(write_addr), 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_err", 32'(err_resp), 32'd0);
    chk_addr1 = 5'd5;
    #1;
    check("rst_hazard1", 32'(hazard1), 32'd0);

    // ALU only
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
    expect_wr(5'd5, 32'h1234);
    #1;
    check("alu_hazard_same_cycle", 32'(hazard1), 32'd0);
    cyc();
    idle();
    #1;
    check("alu_latency_addr", 32'(write_addr), 32'd5);
    check("alu_hazard_next", 32'(hazard1), 32'd0);
    cyc();

    // Collision: load response and ALU beat in the same cycle
    ld_issue_valid = 1'b1; ld_issue_addr = 5'd7;
    cyc();
    idle();
    ld_resp_valid = 1'b1; ld_resp_data = 32'hAAAA;
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h55;
    chk_addr1 = 5'd7; chk_addr2 = 5'd3;
    expect_wr(5'd7, 32'hAAAA);
    expect_wr(5'd3, 32'h55);
    #1;
    check("col_popped_still_hazard", 32'(hazard1), 32'd1);
    check("col_alu_ready_pre", 32'(alu_ready), 32'd1);
    check("col_skid_hazard_pre", 32'(hazard2), 32'd0);
    cyc();
    idle();
    #1;
    check("col_alu_ready_stall", 32'(alu_ready), 32'd0);
    check("col_wr7_addr", 32'(write_addr), 32'd7);
    check("col_skid_hazard", 32'(hazard2), 32'd1);
    check("col_load_hazard_gone", 32'(hazard1), 32'd0);
    cyc();
    #1;
    check("col_alu_ready_back", 32'(alu_ready), 32'd1);
    check("col_wr3_addr", 32'(write_addr), 32'd3);
    check("col_skid_hazard_gone", 32'(hazard2), 32'd0);
    cyc();

    // Queue full
    for (int i = 1; i <= 4; i++) begin
      ld_issue_valid = 1'b1; ld_issue_addr = 5'(i);
      cyc();
    end
    idle();
    chk_addr1 = 5'd2; chk_addr3 = 5'd4;
    #1;
    check("full_ld_ready", 32'(ld_issue_ready), 32'd0);
    check("full_hazard_r2", 32'(hazard1), 32'd1);
    check("full_hazard3_r4", 32'(hazard3), 32'd1);
    ld_issue_valid = 1'b1; ld_issue_addr = 5'd9;
    ld_resp_valid = 1'b1; ld_resp_data = 32'h100;
    expect_wr(5'd1, 32'h100);
    cyc();
    idle();
    chk_addr1 = 5'd9;
    #1;
    check("full_issue_refused", 32'(hazard1), 32'd0);
    check("full_ready_after_pop", 32'(ld_issue_ready), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      ld_resp_valid = 1'b1; ld_resp_data = 32'(i * 'h100);
      expect_wr(5'(i), 32'(i * 'h100));
      cyc();
    end
    idle();
    chk_addr1 = 5'd2; chk_addr3 = 5'd4;
    cyc();
    check("drain_ld_ready", 32'(ld_issue_ready), 32'd1);
    check("drain_hazard_r2", 32'(hazard1), 32'd0);
    check("drain_hazard3_r4", 32'(hazard3), 32'd0);

    // Wrap: overlapped issue/response pairs through the circular queue
    for (int k = 0; k <= 10; k++) begin
      idle();
      if (k < 10) begin
        ld_issue_valid = 1'b1; ld_issue_addr = 5'(10 + k);
      end
      if (k > 0) begin
        ld_resp_valid = 1'b1; ld_resp_data = 32'hB000 + 32'(k - 1);
        expect_wr(5'(10 + k - 1), 32'hB000 + 32'(k - 1));
      end
      cyc();
    end
    idle();
    cyc();
    for (int r = 10; r < 20; r += 3) begin
      chk_addr2 = 5'(r);
      #1;
      check("wrap_no_stale_hazard", 32'(hazard2), 32'd0);
    end
    check("wrap_ld_ready", 32'(ld_issue_ready), 32'd1);

    // Addr 0 load and response on an empty queue
    ld_issue_valid = 1'b1; ld_issue_addr = 5'd0;
    cyc();
    idle();
    ld_resp_valid = 1'b1; ld_resp_data = 32'hDEAD;
    chk_addr1 = 5'd0;
    #1;
    check("r0_hazard", 32'(hazard1), 32'd0);
    cyc();
    idle();
    #1;
    check("r0_no_write", 32'(write_addr), 32'd0);
    check("r0_err_clear", 32'(err_resp), 32'd0);
    ld_resp_valid = 1'b1; ld_resp_data = 32'hBAD;
    cyc();
    idle();
    #1;
    check("err_set", 32'(err_resp), 32'd1);
    check("err_no_write", 32'(write_addr), 32'd0);
    repeat (3) cyc();
    check("err_sticky", 32'(err_resp), 32'd1);

    // Reset mid-operation: two loads pending and skid full
    for (int i = 20; i <= 22; i++) begin
      ld_issue_valid = 1'b1; ld_issue_addr = 5'(i);
      cyc();
    end
    idle();
    ld_resp_valid = 1'b1; ld_resp_data = 32'hC0DE;
    alu_valid = 1'b1; alu_addr = 5'd23; alu_data = 32'h77;
    expect_wr(5'd20, 32'hC0DE);
    cyc();
    idle();
    rst = 1'b1;
    chk_addr1 = 5'd21; chk_addr2 = 5'd22; chk_addr3 = 5'd23;
    #1;
    check("pre_rst_hazard1", 32'(hazard1), 32'd1);
    check("pre_rst_skid_hazard3", 32'(hazard3), 32'd1);
    check("pre_rst_alu_ready", 32'(alu_ready), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    check("mid_rst_hazard1", 32'(hazard1), 32'd0);
    check("mid_rst_hazard2", 32'(hazard2), 32'd0);
    check("mid_rst_hazard3", 32'(hazard3), 32'd0);
    check("mid_rst_alu_ready", 32'(alu_ready), 32'd1);
    check("mid_rst_ld_ready", 32'(ld_issue_ready), 32'd1);
    check("mid_rst_write_addr", 32'(write_addr), 32'd0);
    check("mid_rst_err", 32'(err_resp), 32'd0);
    ld_resp_valid = 1'b1; ld_resp_data = 32'h1;
    cyc();
    idle();
    #1;
    check("post_rst_err", 32'(err_resp), 32'd1);
    check("post_rst_no_write", 32'(write_addr), 32'd0);

    repeat (3) cyc();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
